// File: rtl/pulse_stim_gen.sv
// pulse_stim_gen: launches a train of pulses into a delay chain (chain_in)
// and counts transitions coming back on chain_out after synchronization.
// Ports: clk, rst (async, active-high), start, pulse_width, gap_width,
//   pulse_count (train setup); chain_in (stimulus), chain_out (chain return);
//   busy (train running or draining), done (1-cycle strobe), edges_seen.
module pulse_stim_gen #(
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 64,
  parameter int EDGE_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  gap_width,
  input  logic [CNT_W-1:0]  pulse_count,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] edges_seen
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam int TW = (CNT_W > DW) ? CNT_W : DW;

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  pw_q;
  logic [CNT_W-1:0]  gap_q;
  logic [CNT_W-1:0]  rem;
  logic [TW-1:0]     tmr;
  logic              sync1;
  logic              sync2;
  logic              hist;
  logic              edge_det;

  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYC - 1);

  // Down-counter reload for a phase of v cycles; 0 behaves like 1.
  function automatic logic [TW-1:0] ld(input logic [CNT_W-1:0] v);
    if (v == '0) return '0;
    return TW'(v - CNT_W'(1));
  endfunction

  assign edge_det = sync2 ^ hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pw_q       <= '0;
      gap_q      <= '0;
      rem        <= '0;
      tmr        <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      chain_in   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edges_seen <= '0;
    end else begin
      sync1 <= chain_out;
      sync2 <= sync1;
      hist  <= sync2;
      done  <= 1'b0;

      // Clear on accepted start wins over any edge in that cycle.
      if (state == IDLE) begin
        if (start) edges_seen <= '0;
      end else if (edge_det && edges_seen != '1) begin
        edges_seen <= edges_seen + EDGE_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            pw_q  <= pulse_width;
            gap_q <= gap_width;
            rem   <= pulse_count;
            busy  <= 1'b1;
            if (pulse_count == '0) begin
              state <= DRAIN;
              tmr   <= DRAIN_LD;
            end else begin
              state    <= HIGH;
              tmr      <= ld(pulse_width);
              chain_in <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (tmr == '0) begin
            state    <= LOW;
            tmr      <= ld(gap_q);
            chain_in <= 1'b0;
            rem      <= rem - CNT_W'(1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        LOW: begin
          if (tmr == '0) begin
            if (rem != '0) begin
              state    <= HIGH;
              tmr      <= ld(pw_q);
              chain_in <= 1'b1;
            end else begin
              state <= DRAIN;
              tmr   <= DRAIN_LD;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DRAIN: begin
          if (tmr == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          chain_in <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
